// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    function automatic logic [31:0] mag(
        input logic [31:0] v,
        input logic        sgn
    );
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned 32-bit shift-add multiplier / restoring divider, one bit per step.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    // acc holds {partial, multiplier} or {remainder, quotient}
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] opnd;
    logic [32:0] sum;
    logic [32:0] shifted;
    logic [32:0] trial;

    always_comb begin
        sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        shifted = acc[63:31];
        trial   = shifted - {1'b0, opnd};
        if (is_div) begin
            if (trial[32])
                acc_next = {shifted[31:0], acc[30:0], 1'b0};
            else
                acc_next = {trial[31:0], acc[30:0], 1'b1};
        end else begin
            acc_next = {sum, acc[31:1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {32'd0, is_div ? a : b};
            opnd <= is_div ? b : a;
        end else if (step) begin
            acc  <= acc_next;
        end
    end

    assign result = acc;

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO multiply/divide unit: control FSM, sign fix-up and HI/LO registers.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divide_zero,
    output logic             stall
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             launch;
    logic             div_zero_req;
    logic             load;
    logic             step;
    logic             is_div_in;
    logic             is_signed_in;
    logic             div_q;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;
    logic [31:0]      mag1;
    logic [31:0]      mag2;
    logic [63:0]      raw;
    logic [63:0]      prod;
    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [63:0]      result;

    assign is_div_in    = (op_t'(op) == OP_DIV) || (op_t'(op) == OP_DIVU);
    assign is_signed_in = (op_t'(op) == OP_MULT) || (op_t'(op) == OP_DIV);
    assign mag1         = mag(op1, is_signed_in);
    assign mag2         = mag(op2, is_signed_in);

    assign launch       = (state == S_IDLE) && start;
    assign div_zero_req = launch && is_div_in && (op2 == '0);
    assign last         = (count == CNT_W'(ITER - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Divide-by-zero jumps straight to FIX so completion lands one edge later
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (start) state_next = div_zero_req ? S_FIX : S_RUN;
            S_RUN:  if (last) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        load = 1'b0;
        step = 1'b0;
        unique case (state)
            S_IDLE: load = start && !div_zero_req;
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            S_FIX:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign stall = busy & (start | rd_req | mthi_we | mtlo_we);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz_q  <= 1'b0;
        end else if (launch) begin
            count <= '0;
            div_q <= is_div_in;
            neg_q <= is_signed_in & (op1[31] ^ op2[31]);
            neg_r <= is_signed_in & is_div_in & op1[31];
            dz_q  <= div_zero_req;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    muldiv_core u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (load ? is_div_in : div_q),
        .a      (mag1),
        .b      (mag2),
        .result (raw)
    );

    always_comb begin
        prod   = neg_q ? (64'd0 - raw) : raw;
        quo    = neg_q ? (32'd0 - raw[31:0]) : raw[31:0];
        rem    = neg_r ? (32'd0 - raw[63:32]) : raw[63:32];
        result = div_q ? {rem, quo} : prod;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            divide_zero <= 1'b0;
        end else begin
            done        <= (state == S_FIX);
            divide_zero <= (state == S_FIX) && dz_q;
            if ((state == S_FIX) && !dz_q) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end else if (!busy) begin
                if (mthi_we) hi <= wdata;
                if (mtlo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized scoreboard bench for muldiv_hilo against an arithmetic model.
module tb_muldiv_hilo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        rd_req = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divide_zero;
    logic        stall;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clock = ~clock;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .op1         (op1),
        .op2         (op2),
        .mthi_we     (mthi_we),
        .mtlo_we     (mtlo_we),
        .wdata       (wdata),
        .rd_req      (rd_req),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .divide_zero (divide_zero),
        .stall       (stall)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Returns {HI, LO} straight from integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sbv = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          q;
        longint          r;
        longint unsigned uq;
        longint unsigned ur;
        case (o)
            2'b00: return sa * sbv;
            2'b01: return ua * ub;
            2'b10: begin
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Monitor: every completion pulse pops one expectation
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got hi=%h lo=%h want no done", hi, lo);
            end else begin
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("divide_zero", 64'(divide_zero), 64'(e.dz));
                check("busy_in_done", 64'(busy), 64'd0);
            end
        end else if (divide_zero) begin
            total++;
            bad++;
            $display("FAIL dz_without_done got=1 want=0");
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit mth, input bit mtl,
                          input logic [31:0] wd, input int poke, input bit rel);
        int          n;
        bit          dz;
        logic [63:0] r;
        @(negedge clock);
        if (rel) reset = 1'b1;
        start = 1'b1;
        op = o;
        op1 = a;
        op2 = b;
        mthi_we = mth;
        mtlo_we = mtl;
        wdata = wd;
        #1 check("stall_idle", 64'(stall), 64'd0);
        if (mth) m_hi = wd;
        if (mtl) m_lo = wd;
        dz = o[1] && (b == 32'd0);
        r = dz ? {m_hi, m_lo} : model(o, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
        sb.push_back('{r[63:32], r[31:0], dz});
        @(negedge clock);
        start = 1'b0;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        n = 0;
        check("busy_after_start", 64'(busy), 64'd1);
        while (!done && n < 40) begin
            if (n == poke) begin
                start = 1'b1;
                op = ~o;
                rd_req = 1'b1;
                mthi_we = 1'b1;
                mtlo_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
                #1 check("stall_busy", 64'(stall), 64'd1);
            end
            @(negedge clock);
            start = 1'b0;
            rd_req = 1'b0;
            mthi_we = 1'b0;
            mtlo_we = 1'b0;
            n++;
        end
        check("latency", 64'(n), dz ? 64'd1 : 64'd33);
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] wd);
        @(negedge clock);
        mthi_we = h;
        mtlo_we = l;
        wdata = wd;
        if (h) m_hi = wd;
        if (l) m_lo = wd;
        @(negedge clock);
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(divide_zero), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, '0, 4, 0);
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFFE);
        launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, '0, -1, 0);
        check("multu_hi_const", 64'(hi), 64'h0000_0001);
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, '0, -1, 0);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        launch(2'b11, 32'd100, 32'd7, 0, 0, '0, -1, 0);
        check("divu_lo_const", 64'(lo), 64'd14);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, '0, -1, 0);
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        mt(1, 0, 32'h0000_1234);
        launch(2'b11, 32'd5, 32'd0, 0, 0, '0, 0, 0);
        check("dz_hi_const", 64'(hi), 64'h0000_1234);
        launch(2'b01, 32'h0001_0003, 32'h0002_0005, 1, 1, 32'h5555_AAAA, -1, 0);
        launch(2'b10, 32'd7, 32'd0, 1, 0, 32'h0000_0077, -1, 0);
        mt(1, 1, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(16, 31);
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            launch(2'($urandom_range(0, 3)), a, b,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                   $urandom, ($urandom_range(0, 3) == 0) ? 3 : -1, 0);
        end

        @(negedge clock);
        start = 1'b1;
        op = 2'b00;
        op1 = 32'h1234_5678;
        op2 = 32'h9ABC_DEF0;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clock);
        launch(2'b11, 32'd1000, 32'd33, 0, 0, '0, -1, 1);
        launch(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, '0, -1, 0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
